// File: rtl/rs_issue_queue.sv
// Reservation-station issue queue.
// Pops ops from the dispatch FIFO and holds them in a compacting queue where
// index 0 is always the oldest valid entry. Source operands are woken by CDB
// broadcasts. Each cycle the oldest entry with both sources ready is offered to
// a single functional unit over valid/ready.
module rs_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_empty,
    input  logic [PAYLOAD_W-1:0]         in_payload,
    input  logic [TAG_W-1:0]             in_src1_tag,
    input  logic                         in_src1_rdy,
    input  logic [TAG_W-1:0]             in_src2_tag,
    input  logic                         in_src2_rdy,
    input  logic [TAG_W-1:0]             in_dst_tag,
    output logic                         fifo_deq,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [PAYLOAD_W-1:0]         iss_payload,
    output logic [TAG_W-1:0]             iss_src1_tag,
    output logic [TAG_W-1:0]             iss_src2_tag,
    output logic [TAG_W-1:0]             iss_dst_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [TAG_W-1:0]     s1_tag;
        logic                 s1_rdy;
        logic [TAG_W-1:0]     s2_tag;
        logic                 s2_rdy;
        logic [TAG_W-1:0]     dst_tag;
    } entry_t;

    // Set the rdy bit of any source whose tag matches a valid broadcast.
    // Both sources are compared independently, so duplicate tags wake both.
    function automatic entry_t wake(input entry_t e, input logic v, input logic [TAG_W-1:0] t);
        entry_t r;
        r = e;
        if (v && (e.s1_tag == t)) r.s1_rdy = 1'b1;
        if (v && (e.s2_tag == t)) r.s2_rdy = 1'b1;
        return r;
    endfunction

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           ent_w [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] rdy_vec;
    logic [DEPTH-1:0] shift_m;
    logic [IW-1:0]    sel;
    logic             issue_fire;
    logic             full_w;
    logic [CW-1:0]    ins_pos;
    entry_t           in_raw, in_ent;

    // Ready vector, oldest-ready select, and the shift mask (every index at or above the issued one)
    always_comb begin
        logic acc;
        sel     = '0;
        rdy_vec = '0;
        shift_m = '0;
        acc     = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            rdy_vec[i] = vld_q[i] & ent_q[i].s1_rdy & ent_q[i].s2_rdy;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (rdy_vec[i]) sel = IW'(i);
        for (int i = 0; i < DEPTH; i++) begin
            acc        = acc | rdy_vec[i];
            shift_m[i] = acc & issue_fire;
        end
    end

    // Handshakes; reset and flush force both sides idle combinationally
    assign full_w       = (count_q == CW'(DEPTH));
    assign iss_valid    = (|rdy_vec) && !rst && !flush;
    assign issue_fire   = iss_valid && iss_ready;
    assign fifo_deq     = !in_empty && (!full_w || issue_fire) && !rst && !flush;

    assign iss_payload  = ent_q[sel].payload;
    assign iss_src1_tag = ent_q[sel].s1_tag;
    assign iss_src2_tag = ent_q[sel].s2_tag;
    assign iss_dst_tag  = ent_q[sel].dst_tag;
    assign count        = count_q;
    assign full         = full_w;

    // Incoming op sees the same-cycle broadcast so a wakeup is never lost
    assign in_raw = '{payload: in_payload,
                      s1_tag:  in_src1_tag, s1_rdy: in_src1_rdy,
                      s2_tag:  in_src2_tag, s2_rdy: in_src2_rdy,
                      dst_tag: in_dst_tag};
    assign in_ent  = wake(in_raw, cdb_valid, cdb_tag);

    // After a shift the valid run ends one slot earlier, so insert lands there
    assign ins_pos = count_q - CW'(issue_fire);
    assign count_d = count_q + CW'(fifo_deq) - CW'(issue_fire);

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        entry_t nxt_ent;
        logic   nxt_vld;
        logic   ins_here;

        assign ent_w[i] = wake(ent_q[i], cdb_valid, cdb_tag);

        if (i < DEPTH - 1) begin : g_mid
            assign nxt_ent = shift_m[i] ? ent_w[i+1] : ent_w[i];
            assign nxt_vld = shift_m[i] ? vld_q[i+1] : vld_q[i];
        end else begin : g_last
            assign nxt_ent = ent_w[i];
            assign nxt_vld = vld_q[i] & ~shift_m[i];
        end

        assign ins_here = fifo_deq && (ins_pos == CW'(i));
        assign ent_d[i] = ins_here ? in_ent : nxt_ent;
        assign vld_d[i] = ins_here | nxt_vld;
    end

    // Valid bits and occupancy; flush overrides insert, issue and wakeup
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_q   <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
        end
    end

    // Entry contents carry no reset; stale data behind the valid run is harmless
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            ent_q[i] <= ent_d[i];
    end

    // Valid bits stay packed from index 0 and agree with the occupancy counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((vld_q & (vld_q + DEPTH'(1))) == '0);
            assert (CW'($countones(vld_q)) == count_q);
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue: dispatch, wakeup, bypass, full-queue
// issue+insert, compaction and flush, each with hand-computed expectations.
module tb_rs_issue_queue;

    localparam int DEPTH = 8;
    localparam int TAG_W = 6;
    localparam int PW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst, flush, in_empty;
    logic [PW-1:0]    in_payload;
    logic [TAG_W-1:0] in_src1_tag, in_src2_tag, in_dst_tag;
    logic             in_src1_rdy, in_src2_rdy;
    logic             fifo_deq;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic             iss_valid, iss_ready;
    logic [PW-1:0]    iss_payload;
    logic [TAG_W-1:0] iss_src1_tag, iss_src2_tag, iss_dst_tag;
    logic [CW-1:0]    count;
    logic             full;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rs_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_empty(in_empty),
        .in_payload(in_payload), .in_src1_tag(in_src1_tag), .in_src1_rdy(in_src1_rdy),
        .in_src2_tag(in_src2_tag), .in_src2_rdy(in_src2_rdy), .in_dst_tag(in_dst_tag),
        .fifo_deq(fifo_deq), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload),
        .iss_src1_tag(iss_src1_tag), .iss_src2_tag(iss_src2_tag), .iss_dst_tag(iss_dst_tag),
        .count(count), .full(full)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_empty  = 1'b1;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        iss_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic offer(input logic [PW-1:0] p, input logic [TAG_W-1:0] t1, input logic r1,
                         input logic [TAG_W-1:0] t2, input logic r2, input logic [TAG_W-1:0] d);
        in_empty    = 1'b0;
        in_payload  = p;
        in_src1_tag = t1;
        in_src1_rdy = r1;
        in_src2_tag = t2;
        in_src2_rdy = r2;
        in_dst_tag  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        offer(32'h11, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3);
        iss_ready = 1'b1;
        cdb_valid = 1'b1;
        tick();
        tick();
        checks++; if (fifo_deq !== 1'b0) begin errs++; $display("FAIL reset_deq: got %b want 0", fifo_deq); end
        checks++; if (iss_valid !== 1'b0) begin errs++; $display("FAIL reset_iss_valid: got %b want 0", iss_valid); end
        rst = 1'b0;
        idle();
        #1;
        checks++; if (count !== 4'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (full !== 1'b0) begin errs++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (iss_valid !== 1'b0) begin errs++; $display("FAIL reset_idle_valid: got %b want 0", iss_valid); end
    endtask

    task automatic test_basic();
        offer(32'hA1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3);
        #1;
        checks++; if (fifo_deq !== 1'b1) begin errs++; $display("FAIL basic_deq: got %b want 1", fifo_deq); end
        checks++; if (iss_valid !== 1'b0) begin errs++; $display("FAIL basic_empty_valid: got %b want 0", iss_valid); end
        tick();
        idle();
        #1;
        checks++; if (count !== 4'd1) begin errs++; $display("FAIL basic_count1: got %0d want 1", count); end
        checks++; if (iss_valid !== 1'b1) begin errs++; $display("FAIL basic_valid: got %b want 1", iss_valid); end
        checks++; if (iss_payload !== 32'hA1) begin errs++; $display("FAIL basic_payload: got %h want a1", iss_payload); end
        checks++; if (iss_dst_tag !== 6'd3 || iss_src1_tag !== 6'd1 || iss_src2_tag !== 6'd2) begin
            errs++; $display("FAIL basic_tags: got %0d/%0d/%0d want 1/2/3", iss_src1_tag, iss_src2_tag, iss_dst_tag); end
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errs++; $display("FAIL basic_count0: got %0d want 0", count); end
        checks++; if (iss_valid !== 1'b0) begin errs++; $display("FAIL basic_drained: got %b want 0", iss_valid); end
    endtask

    task automatic test_wakeup();
        offer(32'hAA, 6'd5, 1'b0, 6'd1, 1'b1, 6'd10);
        tick();
        offer(32'hBB, 6'd2, 1'b1, 6'd3, 1'b1, 6'd11);
        tick();
        idle();
        #1;
        checks++; if (count !== 4'd2) begin errs++; $display("FAIL wake_count2: got %0d want 2", count); end
        checks++; if (iss_payload !== 32'hBB || iss_valid !== 1'b1) begin
            errs++; $display("FAIL wake_young_first: got %h/%b want bb/1", iss_payload, iss_valid); end
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        #1;
        checks++; if (count !== 4'd1 || iss_valid !== 1'b0) begin
            errs++; $display("FAIL wake_waiting: got count %0d valid %b want 1/0", count, iss_valid); end
        cdb_valid = 1'b1;
        cdb_tag   = 6'd5;
        iss_ready = 1'b1;
        #1;
        checks++; if (iss_valid !== 1'b0) begin errs++; $display("FAIL wake_same_cycle: got %b want 0", iss_valid); end
        tick();
        cdb_valid = 1'b0;
        #1;
        checks++; if (iss_valid !== 1'b1 || iss_payload !== 32'hAA) begin
            errs++; $display("FAIL wake_next_cycle: got %b/%h want 1/aa", iss_valid, iss_payload); end
        tick();
        iss_ready = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errs++; $display("FAIL wake_count0: got %0d want 0", count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            offer(PW'(100 + i), 6'd1, 1'b1, 6'd2, 1'b1, TAG_W'(i));
            tick();
        end
        offer(PW'(108), 6'd1, 1'b1, 6'd2, 1'b1, 6'd8);
        #1;
        checks++; if (count !== 4'd8 || full !== 1'b1) begin
            errs++; $display("FAIL full_state: got count %0d full %b want 8/1", count, full); end
        checks++; if (fifo_deq !== 1'b0) begin errs++; $display("FAIL full_no_deq: got %b want 0", fifo_deq); end
        checks++; if (iss_payload !== 32'd100) begin errs++; $display("FAIL full_head: got %0d want 100", iss_payload); end
        iss_ready = 1'b1;
        #1;
        checks++; if (fifo_deq !== 1'b1) begin errs++; $display("FAIL full_issue_deq: got %b want 1", fifo_deq); end
        tick();
        in_empty = 1'b1;
        #1;
        checks++; if (count !== 4'd8 || full !== 1'b1) begin
            errs++; $display("FAIL full_swap: got count %0d full %b want 8/1", count, full); end
        for (int k = 1; k <= DEPTH; k++) begin
            checks++; if (iss_valid !== 1'b1 || iss_payload !== PW'(100 + k)) begin
                errs++; $display("FAIL full_order%0d: got %b/%0d want 1/%0d", k, iss_valid, iss_payload, 100 + k); end
            tick();
        end
        iss_ready = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errs++; $display("FAIL full_drain: got %0d want 0", count); end
    endtask

    task automatic test_bypass();
        offer(32'hC0, 6'd4, 1'b1, 6'd9, 1'b0, 6'd12);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd9;
        tick();
        idle();
        #1;
        checks++; if (count !== 4'd1 || iss_valid !== 1'b1) begin
            errs++; $display("FAIL bypass_ready: got count %0d valid %b want 1/1", count, iss_valid); end
        checks++; if (iss_payload !== 32'hC0 || iss_src2_tag !== 6'd9) begin
            errs++; $display("FAIL bypass_entry: got %h/%0d want c0/9", iss_payload, iss_src2_tag); end
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        offer(32'hD0, 6'd7, 1'b0, 6'd7, 1'b0, 6'd13);
        tick();
        idle();
        cdb_valid = 1'b1;
        cdb_tag   = 6'd8;
        tick();
        cdb_valid = 1'b0;
        #1;
        checks++; if (count !== 4'd1 || iss_valid !== 1'b0) begin
            errs++; $display("FAIL dup_nomatch: got count %0d valid %b want 1/0", count, iss_valid); end
        cdb_valid = 1'b1;
        cdb_tag   = 6'd7;
        tick();
        cdb_valid = 1'b0;
        #1;
        checks++; if (iss_valid !== 1'b1 || iss_payload !== 32'hD0) begin
            errs++; $display("FAIL dup_wake: got %b/%h want 1/d0", iss_valid, iss_payload); end
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errs++; $display("FAIL bypass_drain: got %0d want 0", count); end
    endtask

    task automatic test_compact();
        logic [PW-1:0] exp_ord [4];
        exp_ord = '{32'd200, 32'd201, 32'd203, 32'd204};
        offer(32'd200, 6'd20, 1'b0, 6'd30, 1'b1, 6'd0); tick();
        offer(32'd201, 6'd21, 1'b0, 6'd31, 1'b1, 6'd1); tick();
        offer(32'd202, 6'd22, 1'b1, 6'd32, 1'b1, 6'd2); tick();
        offer(32'd203, 6'd23, 1'b0, 6'd33, 1'b1, 6'd3); tick();
        offer(32'd204, 6'd24, 1'b1, 6'd34, 1'b1, 6'd4); tick();
        idle();
        #1;
        checks++; if (count !== 4'd5 || iss_payload !== 32'd202) begin
            errs++; $display("FAIL compact_sel: got count %0d payload %0d want 5/202", count, iss_payload); end
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        #1;
        checks++; if (count !== 4'd4 || iss_payload !== 32'd204) begin
            errs++; $display("FAIL compact_shift: got count %0d payload %0d want 4/204", count, iss_payload); end
        cdb_valid = 1'b1;
        cdb_tag   = 6'd23;
        tick();
        cdb_valid = 1'b0;
        #1;
        checks++; if (iss_payload !== 32'd203 || iss_src1_tag !== 6'd23) begin
            errs++; $display("FAIL compact_idx2: got %0d/%0d want 203/23", iss_payload, iss_src1_tag); end
        cdb_valid = 1'b1;
        cdb_tag   = 6'd20;
        tick();
        cdb_tag   = 6'd21;
        tick();
        cdb_valid = 1'b0;
        iss_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (iss_valid !== 1'b1 || iss_payload !== exp_ord[k]) begin
                errs++; $display("FAIL compact_order%0d: got %b/%0d want 1/%0d", k, iss_valid, iss_payload, exp_ord[k]); end
            tick();
        end
        iss_ready = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errs++; $display("FAIL compact_drain: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 6; i++) begin
            offer(PW'(300 + i), 6'd1, 1'b1, 6'd2, 1'b1, TAG_W'(i));
            tick();
        end
        idle();
        #1;
        checks++; if (count !== 4'd6 || iss_valid !== 1'b1) begin
            errs++; $display("FAIL flush_pre: got count %0d valid %b want 6/1", count, iss_valid); end
        flush = 1'b1;
        offer(32'd399, 6'd1, 1'b1, 6'd2, 1'b1, 6'd9);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd1;
        iss_ready = 1'b1;
        #1;
        checks++; if (fifo_deq !== 1'b0) begin errs++; $display("FAIL flush_deq: got %b want 0", fifo_deq); end
        checks++; if (iss_valid !== 1'b0) begin errs++; $display("FAIL flush_valid: got %b want 0", iss_valid); end
        tick();
        idle();
        #1;
        checks++; if (count !== 4'd0 || iss_valid !== 1'b0 || full !== 1'b0) begin
            errs++; $display("FAIL flush_post: got count %0d valid %b full %b want 0/0/0", count, iss_valid, full); end
        offer(32'd400, 6'd1, 1'b1, 6'd2, 1'b1, 6'd5);
        tick();
        idle();
        #1;
        checks++; if (count !== 4'd1 || iss_payload !== 32'd400) begin
            errs++; $display("FAIL flush_reuse: got count %0d payload %0d want 1/400", count, iss_payload); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        offer('0, '0, 1'b0, '0, 1'b0, '0);
        in_empty = 1'b1;
        test_reset();
        test_basic();
        test_wakeup();
        test_full();
        test_bypass();
        test_compact();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
